// File: rtl/apb4_cmd_master.sv
// APB4 requester driven by a valid/ready command port.
// One transfer in flight; optional ACCESS-phase timeout abort.
module apb4_cmd_master #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_strb_i,
  input  logic [2:0]  cmd_prot_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] paddr_o,
  output logic [2:0]  pprot_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [7:0] TMO_LAST =
    TIMEOUT_CYCLES - 8'd1;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [2:0]  prot_q, prot_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        expire;

  assign expire = (TIMEOUT_CYCLES != 8'd0) &&
                  (cnt_q == TMO_LAST) &&
                  !pready_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          // reads present zero data/strobes on the bus
          wdata_d = cmd_write_i ? cmd_wdata_i : 32'h0;
          strb_d  = cmd_write_i ? cmd_strb_i : 4'h0;
          prot_d  = cmd_prot_i;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = 8'h00;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rdata_d = write_q ? 32'h0 : prdata_i;
          err_d   = pslverr_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (expire) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      prot_q  <= 3'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;
  assign psel_o        = (state_q == SETUP) ||
                         (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign paddr_o       = addr_q;
  assign pprot_o       = prot_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = strb_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Bench for apb4_cmd_master: directed and random APB
// transfers scored against a transaction-level model.
module tb_apb4_cmd_master;

  localparam int TMO = 4;

  logic        pclk;
  logic        presetn;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic [2:0]  cmd_prot_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  int n_cmp = 0;
  int n_err = 0;

  apb4_cmd_master #(
    .TIMEOUT_CYCLES(8'(TMO))
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .cmd_strb_i(cmd_strb_i),
    .cmd_prot_i(cmd_prot_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o),
    .pprot_o(pprot_o),
    .psel_o(psel_o),
    .penable_o(penable_o),
    .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o),
    .pstrb_o(pstrb_o),
    .pready_i(pready_i),
    .prdata_i(prdata_i),
    .pslverr_i(pslverr_i)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic junk_cmd();
    cmd_valid_i = 1'($urandom);
    cmd_write_i = 1'($urandom);
    cmd_addr_i  = $urandom;
    cmd_wdata_i = $urandom;
    cmd_strb_i  = 4'($urandom);
    cmd_prot_i  = 3'($urandom);
  endtask

  task automatic junk_apb();
    pready_i  = 1'($urandom);
    prdata_i  = $urandom;
    pslverr_i = 1'($urandom);
  endtask

  task automatic chk_bus(input string tag,
                         input bit wr,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] st,
                         input logic [2:0] pr);
    chk({tag, "_paddr"}, paddr_o, a);
    chk({tag, "_pwrite"}, 32'(pwrite_o), 32'(wr));
    chk({tag, "_pwdata"}, pwdata_o, wr ? wd : 32'h0);
    chk({tag, "_pstrb"}, 32'(pstrb_o),
        wr ? 32'(st) : 32'h0);
    chk({tag, "_pprot"}, 32'(pprot_o), 32'(pr));
  endtask

  // Called and returns at a negedge with the DUT idle.
  task automatic do_txn(input string tag,
                        input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] st,
                        input logic [2:0] pr,
                        input int waits,
                        input logic [31:0] rd,
                        input bit se,
                        input int rdly);
    bit          e_to;
    int          e_acc;
    logic [31:0] e_rd;
    bit          e_err;
    int          acc;
    e_to  = (TMO != 0) && (waits >= TMO);
    e_acc = e_to ? TMO : waits + 1;
    e_rd  = (e_to || wr) ? 32'h0 : rd;
    e_err = e_to ? 1'b1 : se;

    chk({tag, "_t0_ready"}, 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = a;
    cmd_wdata_i = wd;
    cmd_strb_i  = st;
    cmd_prot_i  = pr;
    junk_apb();
    rsp_ready_i = 1'($urandom);
    @(negedge pclk);
    chk({tag, "_t1_psel"}, 32'(psel_o), 32'd1);
    chk({tag, "_t1_pen"}, 32'(penable_o), 32'd0);
    chk({tag, "_t1_ready"}, 32'(cmd_ready_o), 32'd0);
    chk_bus({tag, "_t1"}, wr, a, wd, st, pr);
    junk_cmd();
    junk_apb();

    acc = 0;
    forever begin
      @(negedge pclk);
      if (!penable_o) break;
      acc++;
      if (acc > 300) begin
        chk({tag, "_access_bound"}, 32'(acc), 32'(e_acc));
        break;
      end
      chk({tag, "_acc_psel"}, 32'(psel_o), 32'd1);
      chk_bus({tag, "_acc"}, wr, a, wd, st, pr);
      junk_cmd();
      pready_i  = (acc - 1 == waits);
      prdata_i  = (acc - 1 == waits) ? rd : $urandom;
      pslverr_i = (acc - 1 == waits) ? se : 1'($urandom);
    end
    chk({tag, "_acc_cycles"}, 32'(acc), 32'(e_acc));

    for (int i = 0; i <= rdly; i++) begin
      chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
      chk({tag, "_rsp_rdata"}, rsp_rdata_o, e_rd);
      chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'(e_err));
      chk({tag, "_rsp_tmo"}, 32'(rsp_timeout_o),
          32'(e_to));
      chk({tag, "_rsp_psel"}, 32'(psel_o), 32'd0);
      chk({tag, "_rsp_ready"}, 32'(cmd_ready_o), 32'd0);
      junk_cmd();
      cmd_valid_i = 1'b1;
      junk_apb();
      rsp_ready_i = (i == rdly);
      @(negedge pclk);
    end
    chk({tag, "_idle_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, "_idle_rspv"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_idle_psel"}, 32'(psel_o), 32'd0);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    presetn     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 32'h0;
    cmd_wdata_i = 32'h0;
    cmd_strb_i  = 4'h0;
    cmd_prot_i  = 3'h0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    prdata_i    = 32'h0;
    pslverr_i   = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", 32'(psel_o), 32'd0);
    chk("rst_rspv", 32'(rsp_valid_o), 32'd0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_pen", 32'(penable_o), 32'd0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_pstrb", 32'(pstrb_o), 32'h0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);

    do_txn("wr0", 1'b1, 32'h0000_0010, 32'hA5A5_5A5A,
           4'hF, 3'h2, 0, 32'hDEAD_BEEF, 1'b0, 0);
    do_txn("rd3", 1'b0, 32'h0000_0104, 32'hFFFF_FFFF,
           4'hF, 3'h1, 3, 32'h1234_5678, 1'b0, 0);
    do_txn("slverr", 1'b1, 32'h0000_0200, 32'h1,
           4'h3, 3'h0, 0, 32'h0, 1'b1, 1);
    do_txn("tmo", 1'b0, 32'h0000_0300, 32'h0,
           4'h0, 3'h4, 20, 32'h5555_AAAA, 1'b0, 0);
    do_txn("tmo_edge", 1'b0, 32'h0000_0304, 32'h0,
           4'h0, 3'h4, TMO - 1, 32'h0BAD_F00D, 1'b0, 0);
    do_txn("bp5", 1'b0, 32'h0000_0400, 32'h0,
           4'h0, 3'h7, 1, 32'hCAFE_0001, 1'b1, 5);
    do_txn("bp_next", 1'b1, 32'h0000_0404, 32'h77,
           4'h1, 3'h0, 0, 32'h0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      do_txn("rnd", 1'($urandom), $urandom, $urandom,
             4'($urandom), 3'($urandom),
             int'($urandom_range(0, 6)), $urandom,
             1'($urandom), int'($urandom_range(0, 3)));
    end

    // reset while in ACCESS
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 32'h0000_0500;
    @(negedge pclk);
    cmd_valid_i = 1'b0;
    pready_i    = 1'b0;
    @(negedge pclk);
    chk("rsta_in_access", 32'(penable_o), 32'd1);
    pready_i = 1'b0;
    #2 presetn = 1'b0;
    #1;
    chk("rsta_psel", 32'(psel_o), 32'd0);
    chk("rsta_pen", 32'(penable_o), 32'd0);
    chk("rsta_rspv", 32'(rsp_valid_o), 32'd0);
    pready_i    = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("rsta_ready", 32'(cmd_ready_o), 32'd1);
      chk("rsta_norsp", 32'(rsp_valid_o), 32'd0);
      chk("rsta_nosel", 32'(psel_o), 32'd0);
    end
    rsp_ready_i = 1'b0;
    do_txn("post_rst", 1'b0, 32'h0000_0600, 32'h0,
           4'h0, 3'h0, 2, 32'h8765_4321, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb4_cmd_master.md
APB4_CMD_MASTER -- requirements
Module: apb4_cmd_master

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd64: number of consecutive ACCESS cycles with pready_i low before abort; 0 disables the timeout.
- REQ-002 SHALL have port pclk, input, 1 bit: single clock; all logic is rising-edge.
- REQ-003 SHALL have port presetn, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have command ports:
  - cmd_valid_i, input, 1: command valid.
  - cmd_ready_o, output, 1: command ready.
  - cmd_write_i, input, 1: 1 = write, 0 = read.
  - cmd_addr_i, input, 32: byte address.
  - cmd_wdata_i, input, 32: write data.
  - cmd_strb_i, input, 4: write byte strobes.
  - cmd_prot_i, input, 3: protection attribute.
- REQ-005 SHALL have response ports:
  - rsp_valid_o, output, 1: response valid.
  - rsp_ready_i, input, 1: response ready.
  - rsp_rdata_o, output, 32: read data.
  - rsp_err_o, output, 1: slave error or timeout.
  - rsp_timeout_o, output, 1: timeout abort.
- REQ-006 SHALL have APB4 requester ports:
  - paddr_o, output, 32.
  - pprot_o, output, 3.
  - psel_o, output, 1.
  - penable_o, output, 1.
  - pwrite_o, output, 1.
  - pwdata_o, output, 32.
  - pstrb_o, output, 4.
  - pready_i, input, 1.
  - prdata_i, input, 32.
  - pslverr_i, input, 1.

Function
- REQ-007 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, with one transfer outstanding at most.
- REQ-008 SHALL drive cmd_ready_o = 1 only in IDLE; a command is accepted when cmd_valid_i && cmd_ready_o, and the FSM goes to SETUP on the next edge.
- REQ-009 SHALL register addr, write, wdata, strb and prot on acceptance, and hold paddr_o/pwrite_o/pwdata_o/pstrb_o/pprot_o stable from SETUP through the last ACCESS cycle.
- REQ-010 SHALL drive pstrb_o = 4'h0 and pwdata_o = 32'h0 for reads.
- REQ-011 SHALL drive psel_o = 1, penable_o = 0 in SETUP, then unconditionally enter ACCESS on the next edge.
- REQ-012 SHALL drive psel_o = 1, penable_o = 1 in ACCESS.
  - Stay in ACCESS while pready_i = 0 and the timeout has not expired.
  - Go to RESP on the edge where pready_i = 1.
- REQ-013 SHALL capture rsp_rdata_o = prdata_i (reads) or 32'h0 (writes), and rsp_err_o = pslverr_i, on the completing ACCESS edge.
- REQ-014 SHALL drive psel_o = 0 and penable_o = 0 in IDLE and RESP; back-to-back APB transfers always have at least two idle bus cycles between them (RESP plus IDLE).
- REQ-015 SHALL hold rsp_valid_o = 1 in RESP with rsp_* stable until rsp_ready_i = 1, then return to IDLE on that edge.
- REQ-016 SHALL give minimum latency, with the accept cycle as T0:
  - SETUP at T1.
  - ACCESS at T2.
  - With pready_i = 1 at T2, rsp_valid_o = 1 at T3.
  - With rsp_ready_i = 1 at T3, cmd_ready_o = 1 at T4.
- REQ-017 SHALL use an 8-bit counter, cleared on entry to ACCESS, that increments each ACCESS cycle with pready_i = 0 and saturates at 8'hFF.
- REQ-018 SHALL abort when TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 with pready_i = 0.
  - Go to RESP on that edge.
  - rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 32'h0.
- REQ-019 SHALL give pready_i = 1 priority over timeout expiry in the same cycle: normal completion, rsp_timeout_o = 0.
- REQ-020 SHALL ignore pslverr_i and prdata_i in every cycle except the completing ACCESS cycle.
- REQ-021 SHALL ignore cmd_* inputs outside the acceptance cycle; no command is accepted while a transfer or response is pending.
- REQ-022 SHALL have rsp_timeout_o = 1 imply rsp_err_o = 1.

Reset
- REQ-023 SHALL on presetn low, asynchronously, with no partial transfer completed and no response produced for it:
  - Force IDLE.
  - Drive psel_o = 0, penable_o = 0, rsp_valid_o = 0, cmd_ready_o = 1 (once presetn is high).
  - Reset all registered address/data/strb/prot/response fields and the timeout counter to 0.
- REQ-024 SHALL, when reset is asserted mid-operation (SETUP, ACCESS or RESP), drop psel_o/penable_o immediately and discard the pending transfer and response.

Verification
- REQ-025 SHALL cover a single write: addr 32'h0000_0010, wdata 32'hA5A5_5A5A, strb 4'hF, pready_i = 1 at T2 -> SETUP at T1, ACCESS at T2, rsp_valid_o at T3 with rsp_err_o = 0.
- REQ-026 SHALL cover a read with 3 wait states, prdata_i = 32'h1234_5678 on the completing cycle -> penable_o high for 4 cycles, rsp_rdata_o = 32'h1234_5678, pstrb_o = 0 throughout.
- REQ-027 SHALL cover a slave error: pslverr_i = 1 with pready_i = 1 -> rsp_err_o = 1, rsp_timeout_o = 0.
- REQ-028 SHALL cover a timeout: TIMEOUT_CYCLES = 4, pready_i held 0 -> exactly 4 ACCESS cycles, then rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0; with pready_i = 1 on the 4th cycle instead -> normal completion.
- REQ-029 SHALL cover response backpressure: rsp_ready_i low for 5 cycles with cmd_valid_i held high -> rsp_* stable, cmd_ready_o = 0, psel_o = 0; the next command is accepted one cycle after the rsp_ready_i handshake.
- REQ-030 SHALL cover reset during ACCESS: presetn low -> psel_o/penable_o = 0 in the same cycle, no rsp_valid_o, cmd_ready_o = 1 after release.
